// File: rtl/seg_scan_if.sv
// seg_scan_if: segment-pattern input and scan-bus outputs of the 7-seg driver.
// master = upstream encoder side, slave = seg_scan_driver.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic [8*NUM_DIGITS-1:0] seg_in;
  logic                    load;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output seg_in, load,
    input  seg_out, dig_sel, pending, frame_done
  );

  modport slave (
    input  seg_in, load,
    output seg_out, dig_sel, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-seg scan, double-buffered per frame.
// Ports: clk, rst (sync, active-high), bus (seg_scan_if.slave):
//   seg_in/load in; seg_out, dig_sel, pending, frame_done out.
// Build option SEG_ACTIVE_LOW_EN: invert seg_out/dig_sel (common anode).
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYCLES);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  localparam logic [7:0]            SEG_OFF = {8{POL}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{POL}};

  typedef logic [NUM_DIGITS-1:0][7:0] buf_t;

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  buf_t                  disp_q, disp_d;
  buf_t                  shad_q, shad_d;
  logic                  pend_q, pend_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  done_q, done_d;

  logic                  last_div;
  logic                  last_idx;
  logic                  bnd;
  logic                  blank;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] dig_raw;

  always_comb begin
    last_div = (div_q == DIV_LAST);
    last_idx = (idx_q == IDX_LAST);
    bnd      = last_div && last_idx;

    div_d = last_div ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (last_div)
      idx_d = last_idx ? '0 : idx_q + IW'(1);

    disp_d = disp_q;
    shad_d = shad_q;
    pend_d = pend_q;
    if (bus.load) begin
      // a load on the boundary bypasses the shadow
      shad_d = bus.seg_in;
      pend_d = !bnd;
      if (bnd)
        disp_d = bus.seg_in;
    end else if (bnd && pend_q) begin
      disp_d = shad_q;
      pend_d = 1'b0;
    end

    blank   = (div_q < BLANK_END);
    seg_raw = blank ? '0 : disp_q[idx_q];
    dig_raw = blank ? '0 : (NUM_DIGITS'(1) << idx_q);
    seg_d   = seg_raw ^ SEG_OFF;
    dig_d   = dig_raw ^ DIG_OFF;
    done_d  = bnd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      shad_q <= '0;
      pend_q <= 1'b0;
      seg_q  <= SEG_OFF;
      dig_q  <= DIG_OFF;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      shad_q <= shad_d;
      pend_q <= pend_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      done_q <= done_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.pending    = pend_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed frames with a cycle-stamped expectation queue.
// A negedge monitor pops and compares every stamped cycle.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = ND * RD;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int              cyc;
    logic [7:0]      seg;
    logic [ND-1:0]   dig;
    logic            pend;
    logic            done;
  } exp_t;

  exp_t q[$];
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(
    input int c, input logic [7:0] s,
    input logic [ND-1:0] d, input logic p,
    input logic dn);
    exp_t e;
    e.cyc  = c;
    e.seg  = s ^ {8{INV}};
    e.dig  = d ^ {ND{INV}};
    e.pend = p;
    e.done = dn;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL stale cyc%0d at cyc%0d", e.cyc, cyc);
      end else if (bus.seg_out !== e.seg ||
                   bus.dig_sel !== e.dig ||
                   bus.pending !== e.pend ||
                   bus.frame_done !== e.done) begin
        n_bad++;
        $display("FAIL cyc%0d got seg=%h dig=%b pend=%b done=%b want seg=%h dig=%b pend=%b done=%b",
                 cyc, bus.seg_out, bus.dig_sel, bus.pending,
                 bus.frame_done, e.seg, e.dig, e.pend, e.done);
      end
    end
  end

  // Called at the negedge where the scan sits at idx0/div0.
  // Expects outputs for n cycles; l1/l2 are load offsets (-1 = none).
  task automatic do_frame(
    input logic [31:0] disp,
    input int l1, input logic [31:0] v1,
    input int l2, input logic [31:0] v2,
    input int n);
    int s;
    s = cyc;
    for (int o = 1; o <= n; o++) begin
      int qd;
      int qi;
      logic [7:0] sg;
      logic [ND-1:0] dg;
      logic p;
      qd = (o - 1) % RD;
      qi = (o - 1) / RD;
      sg = (qd < BC) ? 8'h00 : disp[8*qi +: 8];
      dg = (qd < BC) ? '0 : (ND'(1) << qi);
      p  = (l1 >= 0) && (l1 != FR - 1) &&
           (o > l1) && (o < FR);
      push(s + o, sg, dg, p, o == FR);
    end
    for (int o = 0; o < n; o++) begin
      bus.load = (o == l1) || (o == l2);
      if (o == l1) bus.seg_in = v1;
      else if (o == l2) bus.seg_in = v2;
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.load   = 1'b0;
    bus.seg_in = '0;
    for (int c = 1; c <= 3; c++) push(c, 8'h00, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_frame(32'h0, 10, 32'hE6FE60FC, -1, 32'h0, FR);
    do_frame(32'hE6FE60FC, 5, 32'h11111111,
             8, 32'h22222222, FR);
    do_frame(32'h22222222, FR - 1, 32'h3F065B4F,
             -1, 32'h0, FR);
    do_frame(32'h3F065B4F, 12, 32'h12345678,
             -1, 32'h0, 21);

    push(cyc + 1, 8'h00, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    do_frame(32'h0, -1, 32'h0, -1, 32'h0, FR);
    do_frame(32'h0, -1, 32'h0, -1, 32'h0, FR);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
